// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receive-side decoder for the multiplexed seven-segment bus.
// Samples {an,seg7}, waits SETTLE_CYCLES for each digit to settle, decodes it
// back to BCD and converts the six-digit frame to lo_val (digits 2:0) and
// hi_val (digits 7:5).
// Optional feature: define SEGRX_BLANK_LEADING_EN to decode the all-off
// pattern as 0 in hundreds/tens positions (leading-zero-blanked scanners).
//
// state | meaning
// IDLE  | collecting digits; snapshot slots when all six are seen
// CONV0 | accumulate hundreds digits
// CONV1 | accumulate tens digits
// CONV2 | accumulate ones digits
// DONE  | range check, update outputs or flag err_range
module seg_scan_rx #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] an,
  input  logic [6:0] seg7,
  output logic [7:0] lo_val,
  output logic [7:0] hi_val,
  output logic       frame_valid,
  output logic       err_seg,
  output logic       err_range
);

  localparam logic [7:0] CAP_CNT = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAT_CNT = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, CONV0, CONV1, CONV2, DONE} state_t;

  state_t      state_q, state_d;
  logic [14:0] sample_q;
  logic [7:0]  stab_cnt;
  logic        capture;
  logic        cap_ok;
  logic        cap_lead;
  logic [2:0]  cap_idx;
  logic        dig_ok;
  logic [3:0]  dig_val;
  logic [5:0]  seen, seen_d;
  logic        do_snap;
  logic [3:0]  slot [6];
  logic [3:0]  conv [6];
  logic [9:0]  acc_lo, acc_hi;

  // Input register and saturating stability counter; saturating one past the
  // capture value keeps a long-held pattern from re-capturing.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '1;
      stab_cnt <= '0;
    end else begin
      sample_q <= {an, seg7};
      if ({an, seg7} != sample_q)
        stab_cnt <= '0;
      else if (stab_cnt != SAT_CNT)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign capture = (stab_cnt == CAP_CNT);

  // Map the captured digit enable to a slot index (slots 0..5 = digits 0,1,2,5,6,7).
  always_comb begin
    cap_ok   = 1'b1;
    cap_idx  = 3'd0;
    cap_lead = 1'b0;
    case (sample_q[14:7])
      8'b1111_1110: cap_idx = 3'd0;
      8'b1111_1101: begin cap_idx = 3'd1; cap_lead = 1'b1; end
      8'b1111_1011: begin cap_idx = 3'd2; cap_lead = 1'b1; end
      8'b1101_1111: cap_idx = 3'd3;
      8'b1011_1111: begin cap_idx = 3'd4; cap_lead = 1'b1; end
      8'b0111_1111: begin cap_idx = 3'd5; cap_lead = 1'b1; end
      default:      cap_ok = 1'b0;
    endcase
  end

  // Segment pattern (g..a, active-low) back to BCD.
  always_comb begin
    dig_ok  = 1'b1;
    dig_val = 4'd0;
    case (sample_q[6:0])
      7'b1000000: dig_val = 4'd0;
      7'b1111001: dig_val = 4'd1;
      7'b0100100: dig_val = 4'd2;
      7'b0110000: dig_val = 4'd3;
      7'b0011001: dig_val = 4'd4;
      7'b0010010: dig_val = 4'd5;
      7'b0000010: dig_val = 4'd6;
      7'b1111000: dig_val = 4'd7;
      7'b0000000: dig_val = 4'd8;
      7'b0010000: dig_val = 4'd9;
`ifdef SEGRX_BLANK_LEADING_EN
      7'b1111111: dig_ok = cap_lead;
`endif
      default:    dig_ok = 1'b0;
    endcase
  end

  // Next-state and seen-set update; a capture on the snapshot cycle lands in
  // the freshly cleared set.
  always_comb begin
    state_d = state_q;
    do_snap = 1'b0;
    case (state_q)
      IDLE: if (&seen) begin
        do_snap = 1'b1;
        state_d = CONV0;
      end
      CONV0:   state_d = CONV1;
      CONV1:   state_d = CONV2;
      CONV2:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    seen_d = do_snap ? 6'b0 : seen;
    if (capture && cap_ok)
      seen_d[cap_idx] = dig_ok;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Slot collection, snapshot, conversion and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen        <= '0;
      acc_lo      <= '0;
      acc_hi      <= '0;
      lo_val      <= '0;
      hi_val      <= '0;
      frame_valid <= 1'b0;
      err_seg     <= 1'b0;
      err_range   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        slot[i] <= '0;
        conv[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      err_range   <= 1'b0;
      err_seg     <= capture && cap_ok && !dig_ok;
      seen        <= seen_d;
      if (do_snap)
        for (int i = 0; i < 6; i++) conv[i] <= slot[i];
      if (capture && cap_ok && dig_ok)
        slot[cap_idx] <= dig_val;
      case (state_q)
        CONV0: begin
          acc_lo <= {6'd0, conv[2]};
          acc_hi <= {6'd0, conv[5]};
        end
        CONV1: begin
          acc_lo <= acc_lo * 10'd10 + {6'd0, conv[1]};
          acc_hi <= acc_hi * 10'd10 + {6'd0, conv[4]};
        end
        CONV2: begin
          acc_lo <= acc_lo * 10'd10 + {6'd0, conv[0]};
          acc_hi <= acc_hi * 10'd10 + {6'd0, conv[3]};
        end
        DONE: begin
          if (acc_lo > 10'd255 || acc_hi > 10'd255) begin
            err_range <= 1'b1;
          end else begin
            lo_val      <= acc_lo[7:0];
            hi_val      <= acc_hi[7:0];
            frame_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
